// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage state encoding and default payload widths for pipe_stage_reg
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  typedef enum logic [1:0] {EMPTY = 2'd0, MAIN = 2'd1, FULL = 2'd2} state_e;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: clearable payload register holding the overflow beat (built only with PIPE_STAGE_SKID_EN)
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_entry #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  // clear wins over load so a flush never leaves a stale overflow beat behind
  always_comb q_d = clear ? '0 : load ? d : q_q;
  // payload register
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register, two-entry skid with registered in_ready when PIPE_STAGE_SKID_EN, else one entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);
  localparam int W = CTRL_W + DATA_W;
  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] in_beat;
  logic         accept, drain;
  assign in_beat   = {in_ctrl, in_data};
  assign out_valid = state_q != EMPTY;
  assign drain     = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign occ       = state_q;
  assign out_ctrl  = out_valid ? main_q[W-1:DATA_W] : '0;
  assign out_data  = main_q[DATA_W-1:0];
`ifdef PIPE_STAGE_SKID_EN
  logic         in_ready_q, in_ready_d, skid_load, skid_clear;
  logic [W-1:0] skid_q;
  pipe_skid_entry #(.W(W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_beat),
    .q     (skid_q)
  );
  assign in_ready = in_ready_q;
  // occupancy FSM: overflow goes to the skid entry, which refills main on the next drain
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = MAIN;
          main_d  = in_beat;
        end
        MAIN: if (accept && drain) main_d = in_beat;
          else if (drain) state_d = EMPTY;
          else if (accept) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end
        FULL: if (drain) begin
          state_d    = MAIN;
          main_d     = skid_q;
          skid_clear = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = state_d != FULL;
  end
  // state, main payload and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  // single entry: refill on accept, empty on drain alone, flush discards everything
  always_comb begin
    state_d = flush ? EMPTY : accept ? MAIN : drain ? EMPTY : state_q;
    main_d  = (!flush && accept) ? in_beat : main_q;
  end
  // state and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg, both PIPE_STAGE_SKID_EN builds
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, in_ready, out_valid;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [31:0] in_data, out_data;
  logic [1:0]  occ;
  logic [39:0] exp_q[$];
  int          cnt = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  bit          prev_rst = 1'b0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every downstream transfer must match the oldest beat the model accepted
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      check("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("out_beat", {out_ctrl, out_data}, exp_q.pop_front());
    end
  end

  // one cycle: drive inputs, check occupancy/handshake against the model, record accepts
  task automatic cyc(input bit r, input bit fl, input bit iv, input bit ordy,
                     input logic [7:0] c, input logic [31:0] d);
    rst = r; flush = fl; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    @(negedge clk);
    check("occ", occ, cnt);
    check("out_valid", out_valid, cnt != 0);
    if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_SKID_EN
    check("in_ready", in_ready, cnt < 2);
`else
    check("in_ready", in_ready, cnt == 0 || ordy);
`endif
    if (prev_rst) check("rst_data", out_data, 0);
    if (r || fl) begin
      cnt = 0;
      exp_q.delete();
    end else begin
      if (iv && in_ready) begin
        exp_q.push_back({c, d});
        cnt++;
      end
      if (out_valid && ordy) cnt--;
    end
    prev_rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 8'h07, 32'h0000_1234);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 8'h0A, 32'hA);
    cyc(0, 0, 1, 0, 8'h0B, 32'hB);
    cyc(0, 0, 1, 0, 8'h0C, 32'hC);
    cyc(0, 0, 1, 0, 8'h0C, 32'hC);
    cyc(0, 0, 1, 1, 8'h0C, 32'hC);
    cyc(0, 0, 1, 1, 8'h0C, 32'hC);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 1, 8'(i), 32'(i));
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 8'h1, 32'h1);
    cyc(0, 0, 1, 0, 8'h2, 32'h2);
    cyc(0, 1, 1, 0, 8'h3, 32'h3);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 8'h5, 32'h5);
    cyc(0, 0, 1, 0, 8'h6, 32'h6);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i % 2) == 0, 8'(8'h40 + i), 32'(100 + i));
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 200) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0,
          ($urandom % 3) != 0, 8'($urandom), $urandom);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);
    check("drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
